// File: rtl/avr_serial_pkg.sv
// Shared types and line levels for the FPGA-to-AVR serial transmit path.
package avr_serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/avr_serial_tx_sched_shifter.sv
// 8N1 frame serializer: start bit, eight data bits LSB first, stop bit.
import avr_serial_pkg::*;

module uart_tx_shifter #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       active,
    output logic       done
);

    localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    // Decoded from state so the parent sees the end of STOP on the same edge
    assign done    = (state == STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= IDLE_LVL;
            active   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= START;
                        baud_cnt <= '0;
                        tx       <= START_LVL;
                        active   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            tx    <= STOP_LVL;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state  <= IDLE;
                        active <= 1'b0;
                        tx     <= IDLE_LVL;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift register is pure data: always holds the next bit to drive in bit 0
    always_ff @(posedge clk) begin
        if (state == IDLE && load) begin
            shreg <= data;
        end else if (bit_end && (state == START || state == DATA)) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/avr_serial_tx_sched.sv
// Round-robin, packet-locked scheduler sharing the avr_rx line among N_REQ byte sources.
// Optional AVR_BUSY_SYNC_EN adds a 2-flop synchronizer (reset busy) on avr_rx_busy.
import avr_serial_pkg::*;

module avr_serial_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int CLK_PER_BIT  = 100,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    input  logic               avr_rx_busy,
    output logic               avr_rx,
    output logic               tx_active
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic             busy_eff;
    logic             locked;
    logic             last_pend;
    logic             any_valid;
    logic             load;
    logic             sh_done;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       load_data;

`ifdef AVR_BUSY_SYNC_EN
    logic busy_s1, busy_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_s1 <= 1'b1;
            busy_s2 <= 1'b1;
        end else begin
            busy_s1 <= avr_rx_busy;
            busy_s2 <= busy_s1;
        end
    end

    assign busy_eff = busy_s2;
`else
    assign busy_eff = avr_rx_busy;
`endif

    assign locked = |grant;

    // First valid requester after the pointer, wrapping at N_REQ
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
            if (req_valid[idx] && !any_valid) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!tx_active && locked && req_valid[owner] && !busy_eff) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign load      = |req_ready;
    assign load_data = req_data[{owner, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            idle_cnt  <= '0;
            last_pend <= 1'b0;
        end else if (tx_active) begin
            if (sh_done && last_pend) begin
                grant  <= '0;
                rr_ptr <= owner;
            end
        end else if (load) begin
            last_pend <= req_last[owner];
            idle_cnt  <= '0;
        end else if (locked) begin
            // Only an owner that has gone quiet on a free line ages toward release
            if (!req_valid[owner] && !busy_eff) begin
                if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    grant    <= '0;
                    rr_ptr   <= owner;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end else if (any_valid) begin
            grant    <= N_REQ'(1) << winner;
            owner    <= winner;
            idle_cnt <= '0;
        end
    end

    uart_tx_shifter #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .data   (load_data),
        .tx     (avr_rx),
        .active (tx_active),
        .done   (sh_done)
    );

endmodule

// File: tb/tb_avr_serial_tx_sched.sv
// Self-checking bench for avr_serial_tx_sched: vector table, directed corners, random vs. model.
module tb_avr_serial_tx_sched;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int LT    = 16;
    localparam int FRAME = 10 * CPB;
    // A held lock streams bytes one IDLE cycle apart; a released lock costs an
    // extra cycle for the registered grant before the next byte can be taken.
    localparam int GAP_LOCKED = FRAME + 1;
    localparam int GAP_REARB  = FRAME + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           avr_rx_busy;
    logic           avr_rx;
    logic           tx_active;

    always #5 clk = ~clk;

    avr_serial_tx_sched #(
        .N_REQ(N), .CLK_PER_BIT(CPB), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .avr_rx_busy(avr_rx_busy), .avr_rx(avr_rx), .tx_active(tx_active)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data;
        logic [3:0] last;
        logic       busy;
        int         n;
        logic [3:0] g;
        logic [3:0] r;
        logic       rx;
        logic       act;
    } seg_t;

    seg_t tbl[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dut_who[$];
    int dut_cyc[$];
    logic [N-1:0] s_grant;
    logic         s_active;
    logic         tbl_on = 1'b0;
    logic [2*N+1:0] tbl_exp;

    // Reference model state: who holds the line, where the frame is, which bits it carries
    int m_locked, m_owner, m_ptr, m_cnt, m_t, m_last, m_acc;
    logic [9:0] m_bits;
    logic m_bs1, m_bs2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic m_busy();
`ifdef AVR_BUSY_SYNC_EN
        return m_bs2;
`else
        return avr_rx_busy;
`endif
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = N - 1; m_cnt = 0; m_t = -1; m_last = 0;
        m_bs1 = 1'b1; m_bs2 = 1'b1;
    endtask

    task automatic model_out(output logic [N-1:0] eg, output logic [N-1:0] er,
                             output logic erx, output logic ea);
        eg = '0;
        er = '0;
        if (m_locked != 0) eg[m_owner] = 1'b1;
        if (m_t < 0 && m_locked != 0 && req_valid[m_owner] && !m_busy()) er[m_owner] = 1'b1;
        erx = (m_t < 0) ? 1'b1 : m_bits[m_t / CPB];
        ea  = (m_t >= 0);
    endtask

    task automatic model_step();
        logic [N-1:0] eg, er;
        logic erx, ea, b;
        logic found;
        if (!rst_n) begin
            model_reset();
            return;
        end
        model_out(eg, er, erx, ea);
        b = m_busy();
        m_bs2 = m_bs1;
        m_bs1 = avr_rx_busy;
        if (m_t >= 0) begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = -1;
                if (m_last != 0) begin
                    m_locked = 0;
                    m_ptr = m_owner;
                end
            end
        end else if (er != '0) begin
            m_bits = {1'b1, req_data[m_owner*8 +: 8], 1'b0};
            m_last = int'(req_last[m_owner]);
            m_cnt  = 0;
            m_t    = 0;
            m_acc++;
        end else if (m_locked != 0) begin
            if (!req_valid[m_owner] && !b) begin
                m_cnt++;
                if (m_cnt == LT) begin
                    m_locked = 0;
                    m_ptr = m_owner;
                    m_cnt = 0;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int ix;
                ix = (m_ptr + k) % N;
                if (!found && req_valid[ix]) begin
                    found = 1'b1;
                    m_locked = 1;
                    m_owner = ix;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg, er;
        logic erx, ea;
        @(negedge clk);
        cyc++;
        model_out(eg, er, erx, ea);
        check($sformatf("cycle%0d{grant,ready,rx,active}", cyc),
              32'({grant, req_ready, avr_rx, tx_active}), 32'({eg, er, erx, ea}));
`ifndef AVR_BUSY_SYNC_EN
        if (tbl_on) check($sformatf("table_cycle%0d", cyc),
                          32'({grant, req_ready, avr_rx, tx_active}), 32'(tbl_exp));
`endif
        s_grant  = grant;
        s_active = tx_active;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                dut_who.push_back(i);
                dut_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_acc(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (dut_who.size() < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_accept_seen"}, 32'(dut_who.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        avr_rx_busy = 1'b0;
        model_reset();
        run(2);
        rst_n = 1'b1;
    endtask

    function automatic int who_at(input int i);
        return (i < dut_who.size()) ? dut_who[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i + 1 < dut_cyc.size()) ? dut_cyc[i+1] - dut_cyc[i] : -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        int exp_who[5];
        int n0, c1, c2, held, k, d0, m0;
        logic seen, released;

        // Per-cycle vectors: byte 0xA5 from req 0, then req 1 held off by busy
        a5 = 8'hA5;
        tbl.push_back(seg_t'{4'b0001, 8'hA5, 4'b1111, 1'b0, 1, 4'b0000, 4'b0000, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0001, 8'hA5, 4'b1111, 1'b0, 1, 4'b0001, 4'b0001, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0000, 8'hA5, 4'b1111, 1'b0, CPB, 4'b0001, 4'b0000, 1'b0, 1'b1});
        for (int b = 0; b < 8; b++)
            tbl.push_back(seg_t'{4'b0000, 8'hA5, 4'b1111, 1'b0, CPB, 4'b0001, 4'b0000, a5[b], 1'b1});
        tbl.push_back(seg_t'{4'b0000, 8'hA5, 4'b1111, 1'b0, CPB, 4'b0001, 4'b0000, 1'b1, 1'b1});
        tbl.push_back(seg_t'{4'b0000, 8'hA5, 4'b1111, 1'b0, 2, 4'b0000, 4'b0000, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0010, 8'h3C, 4'b1111, 1'b1, 1, 4'b0000, 4'b0000, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0010, 8'h3C, 4'b1111, 1'b1, 6, 4'b0010, 4'b0000, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0010, 8'h3C, 4'b1111, 1'b0, 1, 4'b0010, 4'b0010, 1'b1, 1'b0});
        tbl.push_back(seg_t'{4'b0000, 8'h3C, 4'b1111, 1'b1, CPB, 4'b0010, 4'b0000, 1'b0, 1'b1});

        do_reset();
        tbl_on = 1'b1;
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                req_valid   = tbl[i].valid;
                req_data    = {N{tbl[i].data}};
                req_last    = tbl[i].last;
                avr_rx_busy = tbl[i].busy;
                tbl_exp     = {tbl[i].g, tbl[i].r, tbl[i].rx, tbl[i].act};
                tick();
            end
        end
        tbl_on = 1'b0;

        // Busy stays high across the frame end: req 2 gets the lock but no accept
        req_valid = 4'b0100;
        req_last  = 4'b1111;
        req_data  = 32'h00_5A_00_00;
        n0 = dut_who.size();
        run(60);
        check("busy_no_accept", 32'(dut_who.size() - n0), 32'd0);
        check("busy_grant_held", 32'(s_grant), 32'(4'b0100));
        avr_rx_busy = 1'b0;
        run_until_acc(n0 + 1, 6, "busy_release");
        check("busy_release_who", 32'(who_at(n0)), 32'd2);
        req_valid = '0;
        run(FRAME + 5);

        // All four requesters, single-byte packets
        do_reset();
        dut_who.delete();
        dut_cyc.delete();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'hD3_C2_B1_A0;
        run_until_acc(5, 6 * GAP_REARB, "rr");
        req_valid = '0;
        exp_who = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(who_at(i)), 32'(exp_who[i]));
        for (int i = 0; i < 4; i++) check($sformatf("rr_gap%0d", i), 32'(gap_at(i)), 32'(GAP_REARB));
        run(FRAME + 5);

        // Req 2 three-byte packet holds the line against a waiting req 1
        dut_who.delete();
        dut_cyc.delete();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data  = 32'h00_60_11_00;
        k = 0;
        while (dut_who.size() < 4 && k < 5 * GAP_REARB) begin
            tick();
            k++;
            c1 = 0;
            c2 = 0;
            foreach (dut_who[i]) begin
                if (dut_who[i] == 1) c1++;
                if (dut_who[i] == 2) c2++;
            end
            req_valid = {1'b0, c2 < 3, c1 < 1, 1'b0};
            req_last  = {1'b0, c2 == 2, 1'b1, 1'b0};
            req_data[23:16] = 8'h60 + 8'(c2);
        end
        check("lock_accepts", 32'(dut_who.size()), 32'd4);
        check("lock_who0", 32'(who_at(0)), 32'd2);
        check("lock_who1", 32'(who_at(1)), 32'd2);
        check("lock_who2", 32'(who_at(2)), 32'd2);
        check("lock_who3", 32'(who_at(3)), 32'd1);
        check("lock_gap0", 32'(gap_at(0)), 32'(GAP_LOCKED));
        check("lock_gap1", 32'(gap_at(1)), 32'(GAP_LOCKED));
        check("lock_gap2", 32'(gap_at(2)), 32'(GAP_REARB));
        req_valid = '0;
        run(FRAME + 5);

        // Req 3 goes quiet after a non-last byte; req 0 waits for the timeout
        dut_who.delete();
        dut_cyc.delete();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        req_data  = 32'h77_00_00_44;
        run_until_acc(1, 10, "timeout_lock3");
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        held = 0;
        seen = 1'b0;
        released = 1'b0;
        for (int i = 0; i < FRAME + 4 * LT && !released; i++) begin
            tick();
            if (s_active) seen = 1'b1;
            else if (seen) begin
                if (s_grant == 4'b1000) held++;
                else released = 1'b1;
            end
        end
        check("timeout_idle_cycles", 32'(held), 32'(LT));
        check("timeout_grant_cleared", 32'(s_grant), 32'd0);
        tick();
        check("timeout_next_grant", 32'(s_grant), 32'(4'b0001));
        run_until_acc(2, 6, "timeout_req0");
        check("timeout_req0_who", 32'(who_at(1)), 32'd0);
        req_valid = '0;
        run(FRAME + 5);

        // Reset in the middle of the data bits
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 32'h00_00_00_C3;
        n0 = dut_who.size();
        run_until_acc(n0 + 1, 6, "mid_reset_setup");
        req_valid = '0;
        run(CPB + 2 * CPB + 1);
        rst_n = 1'b0;
        #2;
        check("rst_avr_rx", 32'(avr_rx), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_active", 32'(tx_active), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        req_data  = 32'h00_22_00_11;
        n0 = dut_who.size();
        run_until_acc(n0 + 1, 8, "post_reset");
        check("post_reset_winner", 32'(who_at(n0)), 32'd0);
        req_valid = '0;
        run(FRAME + 5);

        // Random traffic against the model
        d0 = dut_who.size();
        m0 = m_acc;
        for (int i = 0; i < 2500; i++) begin
            for (int r = 0; r < N; r++) if ($urandom_range(0, 15) == 0) req_valid[r] = ~req_valid[r];
            req_data = $urandom();
            req_last = 4'($urandom());
            if ($urandom_range(0, 39) == 0) avr_rx_busy = ~avr_rx_busy;
            tick();
        end
        check("random_accept_count", 32'(dut_who.size() - d0), 32'(m_acc - m0));
        req_valid = '0;
        avr_rx_busy = 1'b0;
        run(FRAME + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
